// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one hold slot per functional unit and a single registered
// broadcast per cycle, chosen by fixed priority with starvation override or round-robin.
module cdb_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int TAG_W      = 3,
  parameter int DATA_W     = 32,
  parameter int RR_MODE    = 0,
  parameter int STARVE_LIM = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]  src_value,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       squash,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src
);
  localparam int               SRC_W        = $clog2(NUM_SRC);
  localparam logic [7:0]       STARVE_LIM_C = 8'(STARVE_LIM);
  localparam logic [SRC_W-1:0] LAST_IDX_C   = SRC_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] held_r;
  logic [TAG_W-1:0]   tag_r      [NUM_SRC];
  logic [DATA_W-1:0]  value_r    [NUM_SRC];
  logic [7:0]         wait_cnt_r [NUM_SRC];
  logic [SRC_W-1:0]   ptr_r;

  logic [NUM_SRC-1:0] rr_upper_s;
  logic [NUM_SRC-1:0] starved_s;
  logic [NUM_SRC-1:0] cand_s;
  logic [NUM_SRC-1:0] grant_s;
  logic [NUM_SRC-1:0] capture_s;
  logic               grant_any_s;
  logic [SRC_W-1:0]   grant_idx_s;

  // Arbitration: build the candidate set, then grant its lowest index
  always_comb begin
    rr_upper_s  = {NUM_SRC{1'b0}};
    starved_s   = {NUM_SRC{1'b0}};
    cand_s      = {NUM_SRC{1'b0}};
    grant_s     = {NUM_SRC{1'b0}};
    grant_idx_s = {SRC_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      rr_upper_s[i] = held_r[i] & (SRC_W'(i) >= ptr_r);
      starved_s[i]  = held_r[i] & (wait_cnt_r[i] == STARVE_LIM_C);
    end
    // Round-robin wraps to the full held set when nothing sits at or above ptr
    if (RR_MODE != 0) begin
      cand_s = (|rr_upper_s) ? rr_upper_s : held_r;
    end else begin
      cand_s = (|starved_s) ? starved_s : held_r;
    end
    grant_any_s = |cand_s;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      grant_idx_s = cand_s[i] ? SRC_W'(i) : grant_idx_s;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_s[i] = grant_any_s & (grant_idx_s == SRC_W'(i));
    end
  end

  // A slot accepts when empty or being drained this cycle
  always_comb begin
    src_ready = {NUM_SRC{1'b0}};
    if (reset) begin
      src_ready = {NUM_SRC{1'b0}};
    end else begin
      src_ready = ~held_r | grant_s;
    end
    capture_s = src_valid & src_ready;
  end

  // Hold slots and starvation counters
  always_ff @(posedge clock) begin
    if (reset) begin
      held_r <= {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_r[i]      <= {TAG_W{1'b0}};
        value_r[i]    <= {DATA_W{1'b0}};
        wait_cnt_r[i] <= 8'd0;
      end
    end else if (squash) begin
      held_r <= {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        wait_cnt_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (capture_s[i]) begin
          held_r[i]  <= 1'b1;
          tag_r[i]   <= src_tag[i*TAG_W +: TAG_W];
          value_r[i] <= src_value[i*DATA_W +: DATA_W];
        end else if (grant_s[i]) begin
          held_r[i] <= 1'b0;
        end
        if (held_r[i] & ~grant_s[i]) begin
          wait_cnt_r[i] <= (wait_cnt_r[i] == STARVE_LIM_C) ? STARVE_LIM_C : wait_cnt_r[i] + 8'd1;
        end else begin
          wait_cnt_r[i] <= 8'd0;
        end
      end
    end
  end

  // Broadcast register and round-robin pointer; a squash kills the pending grant
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= {TAG_W{1'b0}};
      cdb_value <= {DATA_W{1'b0}};
      cdb_src   <= {SRC_W{1'b0}};
      ptr_r     <= {SRC_W{1'b0}};
    end else if (grant_any_s & ~squash) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= tag_r[grant_idx_s];
      cdb_value <= value_r[grant_idx_s];
      cdb_src   <= grant_idx_s;
      if (RR_MODE != 0) begin
        ptr_r <= (grant_idx_s == LAST_IDX_C) ? {SRC_W{1'b0}} : grant_idx_s + SRC_W'(1'b1);
      end
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: a fixed-priority instance (STARVE_LIM=3)
// and a round-robin instance, each with its own expected-broadcast queue.
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int TW = 3;
  localparam int DW = 32;
  localparam int SW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]    fx_valid, rr_valid;
  logic [N*TW-1:0] fx_tag, rr_tag;
  logic [N*DW-1:0] fx_value, rr_value;
  logic [N-1:0]    fx_ready, rr_ready;
  logic            fx_squash, rr_squash;
  logic            fx_cdb_valid, rr_cdb_valid;
  logic [TW-1:0]   fx_cdb_tag, rr_cdb_tag;
  logic [DW-1:0]   fx_cdb_value, rr_cdb_value;
  logic [SW-1:0]   fx_cdb_src, rr_cdb_src;

  cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .RR_MODE(0), .STARVE_LIM(3)) dut_fx (
    .clock(clock), .reset(reset), .src_valid(fx_valid), .src_tag(fx_tag),
    .src_value(fx_value), .src_ready(fx_ready), .squash(fx_squash),
    .cdb_valid(fx_cdb_valid), .cdb_tag(fx_cdb_tag), .cdb_value(fx_cdb_value),
    .cdb_src(fx_cdb_src));

  cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .RR_MODE(1), .STARVE_LIM(8)) dut_rr (
    .clock(clock), .reset(reset), .src_valid(rr_valid), .src_tag(rr_tag),
    .src_value(rr_value), .src_ready(rr_ready), .squash(rr_squash),
    .cdb_valid(rr_cdb_valid), .cdb_tag(rr_cdb_tag), .cdb_value(rr_cdb_value),
    .cdb_src(rr_cdb_src));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] value;
    logic [SW-1:0] src;
  } bc_t;

  bc_t fx_q[$];
  bc_t rr_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic bc_t mk(input logic [TW-1:0] t, input logic [DW-1:0] v, input logic [SW-1:0] s);
    bc_t r;
    r.tag   = t;
    r.value = v;
    r.src   = s;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Every visible broadcast must match the oldest expected entry of its queue
  task automatic sb_check();
    bc_t e;
    if (fx_cdb_valid) begin
      check("fx_unexpected_bcast", 64'(fx_q.size() != 0), 64'd1);
      if (fx_q.size() != 0) begin
        e = fx_q.pop_front();
        check("fx_tag", 64'(fx_cdb_tag), 64'(e.tag));
        check("fx_value", 64'(fx_cdb_value), 64'(e.value));
        check("fx_src", 64'(fx_cdb_src), 64'(e.src));
      end
    end
    if (rr_cdb_valid) begin
      check("rr_unexpected_bcast", 64'(rr_q.size() != 0), 64'd1);
      if (rr_q.size() != 0) begin
        e = rr_q.pop_front();
        check("rr_tag", 64'(rr_cdb_tag), 64'(e.tag));
        check("rr_value", 64'(rr_cdb_value), 64'(e.value));
        check("rr_src", 64'(rr_cdb_src), 64'(e.src));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    sb_check();
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((fx_q.size() != 0 || rr_q.size() != 0) && guard < 20) begin
      tick();
      guard++;
    end
    check(name, 64'(fx_q.size() + rr_q.size()), 64'd0);
  endtask

  task automatic fx_set(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
    fx_valid[i]          = 1'b1;
    fx_tag[i*TW +: TW]   = t;
    fx_value[i*DW +: DW] = v;
  endtask

  task automatic rr_set(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
    rr_valid[i]          = 1'b1;
    rr_tag[i*TW +: TW]   = t;
    rr_value[i*DW +: DW] = v;
  endtask

  initial begin
    int          n;
    int          guard;
    logic        acc;
    logic [N-1:0] acc_v;
    int          rr_cnt [N];

    fx_valid = '0; fx_tag = '0; fx_value = '0; fx_squash = 1'b0;
    rr_valid = '0; rr_tag = '0; rr_value = '0; rr_squash = 1'b0;
    for (int i = 0; i < N; i++) rr_cnt[i] = 0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(fx_cdb_valid), 64'd0);
    check("rst_tag", 64'(fx_cdb_tag), 64'd0);
    check("rst_value", 64'(fx_cdb_value), 64'd0);
    check("rst_src", 64'(fx_cdb_src), 64'd0);
    check("rst_fx_ready", 64'(fx_ready), 64'd0);
    check("rst_rr_ready", 64'(rr_ready), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_fx_ready", 64'(fx_ready), 64'h1f);
    check("post_rst_rr_ready", 64'(rr_ready), 64'h1f);

    // Single source, one-cycle latency, one-shot valid, held outputs
    fx_set(2, 3'd5, 32'hDEAD_BEEF);
    fx_q.push_back(mk(3'd5, 32'hDEAD_BEEF, 3'd2));
    tick();
    fx_valid = '0;
    check("single_cap_cycle", 64'(fx_cdb_valid), 64'd0);
    check("single_ready2", 64'(fx_ready[2]), 64'd1);
    tick();
    check("single_valid", 64'(fx_cdb_valid), 64'd1);
    tick();
    check("single_one_shot", 64'(fx_cdb_valid), 64'd0);
    check("single_hold_tag", 64'(fx_cdb_tag), 64'd5);
    check("single_hold_src", 64'(fx_cdb_src), 64'd2);

    // Fixed-priority contention between sources 0, 1 and 4
    fx_set(0, 3'd1, 32'h0000_0100);
    fx_set(1, 3'd2, 32'h0000_0200);
    fx_set(4, 3'd0, 32'h0000_0400);
    fx_q.push_back(mk(3'd1, 32'h0000_0100, 3'd0));
    fx_q.push_back(mk(3'd2, 32'h0000_0200, 3'd1));
    fx_q.push_back(mk(3'd0, 32'h0000_0400, 3'd4));
    tick();
    fx_valid = '0;
    check("cont_ready4_c0", 64'(fx_ready[4]), 64'd0);
    tick();
    check("cont_ready4_c1", 64'(fx_ready[4]), 64'd0);
    tick();
    check("cont_ready4_grant", 64'(fx_ready[4]), 64'd1);
    tick();
    check("cont_third_bcast", 64'(fx_cdb_valid), 64'd1);
    tick();
    check("cont_idle", 64'(fx_cdb_valid), 64'd0);
    check("cont_drained", 64'(fx_q.size()), 64'd0);

    // Starvation: source 0 keeps re-presenting while source 3 waits
    for (int v = 0; v < 3; v++) fx_q.push_back(mk(3'd3, 32'hA000_0000 + 32'(v), 3'd0));
    fx_q.push_back(mk(3'd6, 32'h0000_0333, 3'd3));
    fx_q.push_back(mk(3'd3, 32'hA000_0003, 3'd0));
    fx_set(3, 3'd6, 32'h0000_0333);
    n = 0;
    guard = 0;
    while (n < 4 && guard < 20) begin
      fx_set(0, 3'd3, 32'hA000_0000 + 32'(n));
      acc = fx_ready[0];
      tick();
      fx_valid[3] = 1'b0;
      if (acc) n++;
      guard++;
    end
    fx_valid = '0;
    check("starve_src0_accepts", 64'(n), 64'd4);
    tick();
    check("starve_src3_valid", 64'(fx_cdb_valid), 64'd1);
    check("starve_src3_slot", 64'(fx_cdb_src), 64'd3);
    tick();
    check("starve_resume_src0", 64'(fx_cdb_src), 64'd0);
    drain("starve_drained");

    // Squash with held slots 1 and 3 and a concurrent source-0 capture
    fx_set(1, 3'd1, 32'h0000_0111);
    fx_set(3, 3'd3, 32'h0000_0333);
    tick();
    fx_valid = '0;
    fx_set(0, 3'd7, 32'h0000_0BAD);
    fx_squash = 1'b1;
    tick();
    fx_squash = 1'b0;
    fx_valid  = '0;
    check("squash_no_bcast", 64'(fx_cdb_valid), 64'd0);
    check("squash_ready", 64'(fx_ready), 64'h1f);
    tick();
    check("squash_idle1", 64'(fx_cdb_valid), 64'd0);
    tick();
    check("squash_idle2", 64'(fx_cdb_valid), 64'd0);

    // Reset mid-stream with three held slots
    fx_set(0, 3'd4, 32'h0000_0AAA);
    fx_set(2, 3'd5, 32'h0000_0BBB);
    fx_set(4, 3'd6, 32'h0000_0CCC);
    tick();
    fx_valid = '0;
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(fx_cdb_valid), 64'd0);
    check("midrst_tag", 64'(fx_cdb_tag), 64'd0);
    check("midrst_value", 64'(fx_cdb_value), 64'd0);
    check("midrst_src", 64'(fx_cdb_src), 64'd0);
    check("midrst_ready", 64'(fx_ready), 64'd0);
    reset = 1'b0;
    tick();
    check("midrst_ready_after", 64'(fx_ready), 64'h1f);
    check("midrst_no_bcast", 64'(fx_cdb_valid), 64'd0);
    tick();
    check("midrst_still_idle", 64'(fx_cdb_valid), 64'd0);

    // Round-robin wrap with all sources presenting every cycle
    for (int i = 0; i < N; i++) rr_q.push_back(mk(TW'(i), 32'h1000 * 32'(i), SW'(i)));
    rr_q.push_back(mk(3'd0, 32'h0000_0001, 3'd0));
    rr_q.push_back(mk(3'd1, 32'h0000_1001, 3'd1));
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < N; i++) rr_set(i, TW'(i), 32'h1000 * 32'(i) + 32'(rr_cnt[i]));
      acc_v = rr_ready;
      tick();
      for (int i = 0; i < N; i++) if (acc_v[i]) rr_cnt[i]++;
      if (t >= 1) check("rr_every_cycle", 64'(rr_cdb_valid), 64'd1);
    end
    rr_valid = '0;
    tick();
    check("rr_seventh_src", 64'(rr_cdb_src), 64'd1);
    rr_squash = 1'b1;
    tick();
    rr_squash = 1'b0;
    check("rr_squash_idle", 64'(rr_cdb_valid), 64'd0);
    check("rr_squash_ready", 64'(rr_ready), 64'h1f);

    // Pointer survives the squash: search starts at 2, so 3 beats 0
    rr_set(0, 3'd0, 32'h0000_0055);
    rr_set(3, 3'd2, 32'h0000_0066);
    rr_q.push_back(mk(3'd2, 32'h0000_0066, 3'd3));
    rr_q.push_back(mk(3'd0, 32'h0000_0055, 3'd0));
    tick();
    rr_valid = '0;
    drain("rr_ptr_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
